// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalrCalc = 4'd11,
    StJalrLink = 4'd12,
    StLui      = 4'd13,
    StHalt     = 4'd15
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [1:0] ASrcPc    = 2'b00;
  localparam logic [1:0] ASrcOldPc = 2'b01;
  localparam logic [1:0] ASrcReg   = 2'b10;
  localparam logic [1:0] ASrcZero  = 2'b11;

  localparam logic [1:0] BSrcReg   = 2'b00;
  localparam logic [1:0] BSrcImm   = 2'b01;
  localparam logic [1:0] BSrcFour  = 2'b10;

  localparam logic [1:0] ResAluOut = 2'b00;
  localparam logic [1:0] ResMdr    = 2'b01;
  localparam logic [1:0] ResAlu    = 2'b10;

  // beq, bne, blt, bge are the only supported branch flavours.
  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU operation decoder for R- and I-type arithmetic, driven by the latched fields.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] f3_i,
  input  logic [6:0] f7_i,
  output logic [2:0] alu_op_o,
  output logic       illegal_o
);

  logic is_r;

  // Map funct3/funct7 to an ALU operation; shifts and unknown funct7 are flagged illegal.
  always_comb begin
    alu_op_o  = AluAdd;
    illegal_o = 1'b0;
    is_r      = (op_i == OpR);
    unique case (f3_i)
      3'b000: begin
        if (is_r && f7_i == 7'b0100000) begin
          alu_op_o = AluSub;
        end else if (is_r && f7_i != 7'b0000000) begin
          illegal_o = 1'b1;
        end
      end
      3'b111:  alu_op_o = AluAnd;
      3'b110:  alu_op_o = AluOr;
      3'b100:  alu_op_o = AluXor;
      3'b010:  alu_op_o = AluSlt;
      3'b011:  alu_op_o = AluSltu;
      default: illegal_o = 1'b1;
    endcase
    // Register forms other than add/sub only accept funct7 == 0.
    if (is_r && f3_i != 3'b000 && f7_i != 7'b0000000) begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32 control FSM: one state per cycle, fields captured at fetch.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned STRICT_DECODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] f3,
  input  logic [6:0] f7,
  input  logic       z,
  input  logic       s,
  output logic       PC_update,
  output logic       Adr_src,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic       IR_wr,
  output logic [2:0] imm_src,
  output logic [1:0] A_src,
  output logic [1:0] B_src,
  output logic [2:0] ALU_op,
  output logic [1:0] result_src,
  output logic       halted,
  output logic [3:0] state_o
);

  localparam state_e IllegalNext = (STRICT_DECODE != 0) ? StHalt : StFetch;

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d, f7_q, f7_d;
  logic [2:0] f3_q, f3_d;
  logic [2:0] alu_op;
  logic       alu_illegal;
  logic       taken;
  logic       pc_update_raw, mem_wr_raw, reg_wr_raw, ir_wr_raw;

  mc_alu_decoder u_alu_decoder (
    .op_i      (op_q),
    .f3_i      (f3_q),
    .f7_i      (f7_q),
    .alu_op_o  (alu_op),
    .illegal_o (alu_illegal)
  );

  // Capture instruction fields alongside the IR write in FETCH.
  always_comb begin
    op_d = op_q;
    f3_d = f3_q;
    f7_d = f7_q;
    if (state_q == StFetch) begin
      op_d = op;
      f3_d = f3;
      f7_d = f7;
    end
  end

  // State and latched-field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= 7'd0;
      f3_q    <= 3'd0;
      f7_q    <= 7'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
    end
  end

  // Branch condition from the live ALU flags of the subtraction.
  always_comb begin
    taken = 1'b0;
    case (f3_q)
      3'b000:  taken = z;
      3'b001:  taken = !z;
      3'b100:  taken = s;
      3'b101:  taken = !s;
      default: taken = 1'b0;
    endcase
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d       = state_q;
    pc_update_raw = 1'b0;
    mem_wr_raw    = 1'b0;
    reg_wr_raw    = 1'b0;
    ir_wr_raw     = 1'b0;
    Adr_src       = 1'b0;
    imm_src       = ImmI;
    A_src         = ASrcPc;
    B_src         = BSrcReg;
    ALU_op        = AluAdd;
    result_src    = ResAluOut;
    case (state_q)
      StFetch: begin
        ir_wr_raw     = 1'b1;
        B_src         = BSrcFour;
        result_src    = ResAlu;
        pc_update_raw = 1'b1;
        state_d       = StDecode;
      end
      StDecode: begin
        A_src   = ASrcOldPc;
        B_src   = BSrcImm;
        imm_src = (op_q == OpJal) ? ImmJ : ImmB;
        case (op_q)
          OpR:      state_d = alu_illegal ? IllegalNext : StExecR;
          OpI:      state_d = alu_illegal ? IllegalNext : StExecI;
          OpLoad,
          OpStore:  state_d = (f3_q == 3'b010) ? StMemAdr : IllegalNext;
          OpBranch: state_d = is_branch_f3(f3_q) ? StBranch : IllegalNext;
          OpJal:    state_d = StJal;
          OpJalr:   state_d = StJalrCalc;
          OpLui:    state_d = StLui;
          default:  state_d = IllegalNext;
        endcase
      end
      StMemAdr: begin
        A_src   = ASrcReg;
        B_src   = BSrcImm;
        imm_src = (op_q == OpStore) ? ImmS : ImmI;
        state_d = (op_q == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        Adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResMdr;
        reg_wr_raw = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        Adr_src    = 1'b1;
        mem_wr_raw = 1'b1;
        state_d    = StFetch;
      end
      StExecR: begin
        A_src   = ASrcReg;
        ALU_op  = alu_op;
        state_d = StAluWb;
      end
      StExecI: begin
        A_src   = ASrcReg;
        B_src   = BSrcImm;
        ALU_op  = alu_op;
        state_d = StAluWb;
      end
      StAluWb: begin
        reg_wr_raw = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        A_src         = ASrcReg;
        ALU_op        = AluSub;
        pc_update_raw = taken;
        state_d       = StFetch;
      end
      StJal, StJalrLink: begin
        // Link value oldPC+4 goes through the ALU while PC takes the precomputed target.
        A_src         = ASrcOldPc;
        B_src         = BSrcFour;
        pc_update_raw = 1'b1;
        state_d       = StAluWb;
      end
      StJalrCalc: begin
        A_src   = ASrcReg;
        B_src   = BSrcImm;
        state_d = StJalrLink;
      end
      StLui: begin
        A_src   = ASrcZero;
        B_src   = BSrcImm;
        imm_src = ImmU;
        state_d = StAluWb;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Enables are forced low the moment reset asserts so no partial write lands.
  assign PC_update = pc_update_raw & rst_n;
  assign mem_wr    = mem_wr_raw & rst_n;
  assign reg_wr    = reg_wr_raw & rst_n;
  assign IR_wr     = ir_wr_raw & rst_n;
  assign halted    = (state_q == StHalt);
  assign state_o   = state_q;

endmodule
